mont_ram_sequencer: RTL and testbench
=====================================

Name: mont_ram_sequencer

Overview:
- Sequences one Montgomery multiplication over the shared 32-bit/512-bit operand RAM.
- Collects three completed RAM frames (A, B, M) into core operand registers, then pulses core start and waits for core done.
- Writes the core result back through the RAM wide port, retrying if a host write collides, and pulses op_done.
- Sits between the operand RAM and the Montgomery core(s) inside the Montgomery interface IP.

Parameters:
- NUM_OF_CORES, 1, number of 512-bit lanes; W = NUM_OF_CORES*512.
- CORE_TIMEOUT, 4095, max cycles in WAIT_CORE before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- doutb  in  W  RAM wide read data
- doutb_valid  in  1  one-cycle pulse: RAM frame complete
- dinb  out  W  result to RAM wide write port (registered)
- web  out  1  RAM wide write enable
- dinb_read  in  1  RAM acknowledge, one cycle after an accepted web
- cfg_reuse_mod  in  1  skip frame M; reuse stored modulus if valid
- core_a, core_b, core_m  out  W each  registered operands
- core_start  out  1  one-cycle start pulse
- core_done  in  1  one-cycle core completion pulse
- core_result  in  W  core result, valid with core_done
- busy  out  1  high in every state except IDLE
- op_done  out  1  one-cycle completion pulse
- err_overrun  out  1  sticky: frame arrived while not loading
- err_timeout  out  1  sticky: core watchdog expired
- err_clear  in  1  clears both sticky errors

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; core_a/b/m and dinb 0; m_valid 0; timeout counter 0.
- States: IDLE, LOAD_B, LOAD_M, START, WAIT_CORE, WRITEBACK, WAIT_ACK, DONE.
- IDLE: on doutb_valid, core_a <= doutb; go LOAD_B.
- LOAD_B: on doutb_valid, core_b <= doutb.
  - Go START if cfg_reuse_mod && m_valid (cfg_reuse_mod sampled in that same cycle).
  - Otherwise go LOAD_M.
- LOAD_M: on doutb_valid, core_m <= doutb and m_valid <= 1; go START.
- START: core_start = 1 for exactly one cycle; clear timeout counter; go WAIT_CORE.
- WAIT_CORE:
  - On core_done: dinb <= core_result; go WRITEBACK.
  - Else, if CORE_TIMEOUT != 0 and counter == CORE_TIMEOUT-1: set err_timeout; go IDLE (no writeback, no op_done).
- WRITEBACK: web = 1 for one cycle; go WAIT_ACK.
- WAIT_ACK:
  - dinb_read = 1: go DONE.
  - dinb_read = 0 (write lost to a simultaneous 32-bit host write): go WRITEBACK and retry. Retries are unbounded; dinb stays stable.
- DONE: op_done = 1 for one cycle; go IDLE.
- Latency:
  - Final frame valid at cycle t gives core_start at t+1.
  - core_done at t gives web at t+1, dinb_read at t+2, op_done at t+3 when there is no collision.
- doutb_valid in START..DONE: frame ignored; err_overrun set. Operand registers are not disturbed.
- err_clear: clears both errors next cycle. Same-cycle set and clear: set wins.
- core_done outside WAIT_CORE: ignored.
- Operand registers hold their values after the op (readable for debug). m_valid persists until reset.
- Counter width: $clog2(CORE_TIMEOUT+1); no wrap (saturates at abort).

Decomposition:
- Shared package mont_pkg:
  - State enum (3-bit encoding).
  - LANE_BITS = 512.
  - Width function W(NUM_OF_CORES).
- One sub-module, mont_watchdog: counter with clear, enable and limit, and an expired output. Everything else lives in the top.

Test Plan:
- Full op, NUM_OF_CORES=1:
  - Stimulus: frames A=5, B=7, M=11; core model returns 2 after 20 cycles.
  - Required: core_a/b/m = 5/7/11; core_start is one pulse one cycle after the third frame; dinb=2; web pulse, dinb_read, then op_done exactly 3 cycles after core_done; busy low afterward.
- Reuse modulus:
  - Stimulus: after the first op, assert cfg_reuse_mod; send A=3, B=4 only.
  - Required: core_start one cycle after B; core_m still 11; op_done follows.
- Writeback collision:
  - Stimulus: force dinb_read low on the first ack cycle.
  - Required: web re-asserted two cycles after the first web; op_done one cycle after the second dinb_read; dinb unchanged.
- Watchdog:
  - Stimulus: CORE_TIMEOUT=16; core never signals done.
  - Required: err_timeout set 16 cycles after core_start; state IDLE; no web, no op_done; err_clear drops err_timeout next cycle.
- Overrun:
  - Stimulus: pulse doutb_valid with 0xFF.. during WAIT_CORE.
  - Required: err_overrun=1; core_a/b/m unchanged; op completes normally.
- Reset mid-op:
  - Stimulus: assert reset asynchronously in WAIT_CORE.
  - Required: all outputs 0 immediately; m_valid 0; a following cfg_reuse_mod op still waits for frame M.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared types and sizing helpers for the Montgomery interface sequencer.
package mont_pkg;

   localparam int unsigned LANE_BITS = 512;

   typedef enum logic [2:0] {
      StIdle,
      StLoadB,
      StLoadM,
      StStart,
      StWaitCore,
      StWriteback,
      StWaitAck,
      StDone
   } mont_state_e;

   // Total operand width for a given number of 512-bit lanes.
   function automatic int unsigned w_bits(input int unsigned num_of_cores);
      return num_of_cores * LANE_BITS;
   endfunction

endpackage

// File: rtl/mont_watchdog.sv
// Saturating cycle counter that flags when the core has taken too long.
module mont_watchdog #(
   parameter int unsigned Limit = 4095
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CntW = (Limit == 0) ? 1 : $clog2(Limit + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'((Limit == 0) ? 0 : Limit - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Count while enabled, holding at the last value so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LastCnt)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A limit of zero disables the watchdog entirely.
   assign expired_o = (Limit != 0) && enable_i && !clear_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mont_ram_sequencer.sv
// Sequences one Montgomery multiplication: gathers A/B/M frames from the operand RAM,
// starts the core, and writes the result back through the RAM wide port.
module mont_ram_sequencer
   import mont_pkg::*;
#(
   parameter int unsigned NUM_OF_CORES = 1,
   parameter int unsigned CORE_TIMEOUT = 4095,
   localparam int unsigned W = w_bits(NUM_OF_CORES)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] doutb,
   input  logic         doutb_valid,
   output logic [W-1:0] dinb,
   output logic         web,
   input  logic         dinb_read,
   input  logic         cfg_reuse_mod,
   output logic [W-1:0] core_a,
   output logic [W-1:0] core_b,
   output logic [W-1:0] core_m,
   output logic         core_start,
   input  logic         core_done,
   input  logic [W-1:0] core_result,
   output logic         busy,
   output logic         op_done,
   output logic         err_overrun,
   output logic         err_timeout,
   input  logic         err_clear
);

   mont_state_e  state_q;
   logic [W-1:0] core_a_q, core_b_q, core_m_q, dinb_q;
   logic         m_valid_q;
   logic         core_start_q, web_q, op_done_q;
   logic         err_overrun_q, err_timeout_q;
   logic         wd_run, wd_expired, overrun_window;

   // The counter is held at zero outside START/WAIT_CORE, so it is clear on entry to START
   // and the START cycle itself counts toward the limit.
   assign wd_run = (state_q == StStart) || (state_q == StWaitCore);

   // Frames are only expected while collecting operands.
   assign overrun_window = !((state_q == StIdle) || (state_q == StLoadB) ||
                             (state_q == StLoadM));

   mont_watchdog #(
      .Limit(CORE_TIMEOUT)
   ) u_watchdog (
      .clk_i    (clk),
      .rst_i    (reset),
      .clear_i  (!wd_run),
      .enable_i (wd_run),
      .expired_o(wd_expired)
   );

   // Sequencer FSM with registered operands, strobes and sticky errors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         core_a_q      <= '0;
         core_b_q      <= '0;
         core_m_q      <= '0;
         dinb_q        <= '0;
         m_valid_q     <= 1'b0;
         core_start_q  <= 1'b0;
         web_q         <= 1'b0;
         op_done_q     <= 1'b0;
         err_overrun_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         web_q        <= 1'b0;
         op_done_q    <= 1'b0;
         // Clear first; any set below in the same cycle takes precedence.
         if (err_clear) begin
            err_overrun_q <= 1'b0;
            err_timeout_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (doutb_valid) begin
                  core_a_q <= doutb;
                  state_q  <= StLoadB;
               end
            end
            StLoadB: begin
               if (doutb_valid) begin
                  core_b_q <= doutb;
                  if (cfg_reuse_mod && m_valid_q) begin
                     core_start_q <= 1'b1;
                     state_q      <= StStart;
                  end else begin
                     state_q <= StLoadM;
                  end
               end
            end
            StLoadM: begin
               if (doutb_valid) begin
                  core_m_q     <= doutb;
                  m_valid_q    <= 1'b1;
                  core_start_q <= 1'b1;
                  state_q      <= StStart;
               end
            end
            StStart: begin
               state_q <= StWaitCore;
            end
            StWaitCore: begin
               if (core_done) begin
                  dinb_q  <= core_result;
                  web_q   <= 1'b1;
                  state_q <= StWriteback;
               end else if (wd_expired) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= StIdle;
               end
            end
            StWriteback: begin
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               // No ack means a host write won the port; retry with the same data.
               if (dinb_read) begin
                  op_done_q <= 1'b1;
                  state_q   <= StDone;
               end else begin
                  web_q   <= 1'b1;
                  state_q <= StWriteback;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
         if (doutb_valid && overrun_window) begin
            err_overrun_q <= 1'b1;
         end
      end
   end

   assign core_a      = core_a_q;
   assign core_b      = core_b_q;
   assign core_m      = core_m_q;
   assign dinb        = dinb_q;
   assign core_start  = core_start_q;
   assign web         = web_q;
   assign op_done     = op_done_q;
   assign err_overrun = err_overrun_q;
   assign err_timeout = err_timeout_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mont_ram_sequencer.sv
// Randomised self-checking bench for mont_ram_sequencer against a frame-level model.
module tb_mont_ram_sequencer;

   localparam int unsigned W = 512;

   logic         clk, reset;
   logic [W-1:0] doutb, core_result;
   logic         doutb_valid, wd_valid, dinb_read, cfg_reuse_mod, core_done, err_clear;
   logic         wd_core_done;

   logic [W-1:0] dinb, core_a, core_b, core_m;
   logic         web, core_start, busy, op_done, err_overrun, err_timeout;
   logic [W-1:0] w_dinb, w_core_a, w_core_b, w_core_m;
   logic         w_web, w_core_start, w_busy, w_op_done, w_err_overrun, w_err_timeout;

   int checks = 0;
   int errors = 0;

   // Reference model: operand registers, modulus-valid flag and sticky overrun flag.
   logic [W-1:0] exp_a, exp_b, exp_m;
   bit           exp_mvalid, exp_ovr;

   mont_ram_sequencer #(.NUM_OF_CORES(1)) dut (
      .clk(clk), .reset(reset), .doutb(doutb), .doutb_valid(doutb_valid), .dinb(dinb),
      .web(web), .dinb_read(dinb_read), .cfg_reuse_mod(cfg_reuse_mod), .core_a(core_a),
      .core_b(core_b), .core_m(core_m), .core_start(core_start), .core_done(core_done),
      .core_result(core_result), .busy(busy), .op_done(op_done), .err_overrun(err_overrun),
      .err_timeout(err_timeout), .err_clear(err_clear)
   );

   mont_ram_sequencer #(.NUM_OF_CORES(1), .CORE_TIMEOUT(16)) dut_wd (
      .clk(clk), .reset(reset), .doutb(doutb), .doutb_valid(wd_valid), .dinb(w_dinb),
      .web(w_web), .dinb_read(dinb_read), .cfg_reuse_mod(cfg_reuse_mod), .core_a(w_core_a),
      .core_b(w_core_b), .core_m(w_core_m), .core_start(w_core_start),
      .core_done(wd_core_done), .core_result(core_result), .busy(w_busy), .op_done(w_op_done),
      .err_overrun(w_err_overrun), .err_timeout(w_err_timeout), .err_clear(err_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [W-1:0] v);
      doutb       = v;
      doutb_valid = 1'b1;
      tick();
      doutb_valid = 1'b0;
   endtask

   function automatic logic [W-1:0] rnd_wide();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One complete operation; optionally injects ack collisions and a mid-op overrun frame.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                         input bit reuse, input int lat, input logic [W-1:0] res,
                         input int ncoll, input bit ovr, input string tag);
      bit need_m;
      bit saw_web;
      cfg_reuse_mod = reuse;
      need_m = !(reuse && exp_mvalid);
      send_frame(a);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_a got %b want 1", tag, busy); end
      send_frame(b);
      if (need_m) begin
         checks++;
         if (core_start !== 1'b0) begin
            errors++; $display("FAIL %s start_before_m got %b want 0", tag, core_start);
         end
         send_frame(m);
      end
      exp_a = a;
      exp_b = b;
      if (need_m) begin exp_m = m; exp_mvalid = 1'b1; end
      checks++;
      if (core_start !== 1'b1) begin errors++; $display("FAIL %s core_start got %b want 1", tag, core_start); end
      checks++;
      if (core_a !== exp_a) begin errors++; $display("FAIL %s core_a got %0h want %0h", tag, core_a, exp_a); end
      checks++;
      if (core_b !== exp_b) begin errors++; $display("FAIL %s core_b got %0h want %0h", tag, core_b, exp_b); end
      checks++;
      if (core_m !== exp_m) begin errors++; $display("FAIL %s core_m got %0h want %0h", tag, core_m, exp_m); end
      tick();
      checks++;
      if (core_start !== 1'b0) begin errors++; $display("FAIL %s start_pulse got %b want 0", tag, core_start); end
      saw_web = 1'b0;
      for (int i = 0; i < lat; i++) begin
         if (ovr && i == lat / 2) begin
            // Stray frame with a simultaneous clear: the set must win.
            doutb       = '1;
            doutb_valid = 1'b1;
            err_clear   = 1'b1;
            tick();
            doutb_valid = 1'b0;
            err_clear   = 1'b0;
            exp_ovr     = 1'b1;
         end else begin
            tick();
         end
         if (web) saw_web = 1'b1;
      end
      checks++;
      if (saw_web !== 1'b0) begin errors++; $display("FAIL %s early_web got %b want 0", tag, saw_web); end
      if (ovr) begin
         checks++;
         if (err_overrun !== exp_ovr) begin
            errors++; $display("FAIL %s err_overrun got %b want %b", tag, err_overrun, exp_ovr);
         end
         checks++;
         if ({core_a, core_b} !== {exp_a, exp_b}) begin
            errors++; $display("FAIL %s ab_disturbed got %0h want %0h", tag, core_a, exp_a);
         end
         checks++;
         if (core_m !== exp_m) begin
            errors++; $display("FAIL %s m_disturbed got %0h want %0h", tag, core_m, exp_m);
         end
      end
      core_result = res;
      core_done   = 1'b1;
      tick();
      core_done   = 1'b0;
      core_result = rnd_wide();
      checks++;
      if (web !== 1'b1) begin errors++; $display("FAIL %s web got %b want 1", tag, web); end
      checks++;
      if (dinb !== res) begin errors++; $display("FAIL %s dinb got %0h want %0h", tag, dinb, res); end
      for (int c = 0; c < ncoll; c++) begin
         tick();
         checks++;
         if (web !== 1'b0) begin errors++; $display("FAIL %s web_gap got %b want 0", tag, web); end
         tick();
         checks++;
         if ({web, dinb} !== {1'b1, res}) begin
            errors++; $display("FAIL %s retry got web=%b dinb=%0h want web=1 dinb=%0h", tag, web, dinb, res);
         end
      end
      tick();
      dinb_read = 1'b1;
      checks++;
      if (op_done !== 1'b0) begin errors++; $display("FAIL %s op_done_early got %b want 0", tag, op_done); end
      tick();
      dinb_read = 1'b0;
      checks++;
      if (op_done !== 1'b1) begin errors++; $display("FAIL %s op_done got %b want 1", tag, op_done); end
      tick();
      checks++;
      if ({op_done, busy, err_timeout} !== 3'b000) begin
         errors++; $display("FAIL %s idle_after got %b want 000", tag, {op_done, busy, err_timeout});
      end
      cfg_reuse_mod = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, web, core_start, op_done, err_overrun, err_timeout} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b want 0", {busy, web, core_start, op_done, err_overrun, err_timeout});
      end
      checks++;
      if ((dinb | core_a | core_b | core_m) !== '0) begin
         errors++; $display("FAIL reset_data got %0h want 0", dinb | core_a | core_b | core_m);
      end
      checks++;
      if ({w_busy, w_web, w_core_start, w_op_done, w_err_overrun, w_err_timeout} !== 6'b0 ||
          (w_dinb | w_core_a | w_core_b | w_core_m) !== '0) begin
         errors++; $display("FAIL reset_wd got busy=%b want 0", w_busy);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_full_op();
      run_op(512'd5, 512'd7, 512'd11, 1'b0, 20, 512'd2, 0, 1'b0, "full_op");
   endtask

   task automatic test_reuse_mod();
      run_op(512'd3, 512'd4, rnd_wide(), 1'b1, $urandom_range(3, 30), rnd_wide(), 0, 1'b0, "reuse");
      run_op(rnd_wide(), rnd_wide(), rnd_wide(), 1'b1, $urandom_range(1, 10), rnd_wide(), 0, 1'b0,
             "reuse_rnd");
   endtask

   task automatic test_collision();
      run_op(rnd_wide(), rnd_wide(), rnd_wide(), 1'b0, $urandom_range(2, 12), rnd_wide(), 1, 1'b0,
             "collide1");
      run_op(rnd_wide(), rnd_wide(), rnd_wide(), 1'b0, $urandom_range(2, 12), rnd_wide(),
             $urandom_range(2, 4), 1'b0, "collide_n");
   endtask

   task automatic test_overrun();
      run_op(rnd_wide(), rnd_wide(), rnd_wide(), 1'b0, $urandom_range(4, 16), rnd_wide(), 0, 1'b1,
             "overrun");
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      exp_ovr   = 1'b0;
      checks++;
      if (err_overrun !== exp_ovr) begin
         errors++; $display("FAIL overrun_clear got %b want %b", err_overrun, exp_ovr);
      end
   endtask

   task automatic test_watchdog();
      bit saw_strobe;
      for (int f = 0; f < 3; f++) begin
         doutb    = rnd_wide();
         wd_valid = 1'b1;
         tick();
         wd_valid = 1'b0;
      end
      checks++;
      if (w_core_start !== 1'b1) begin errors++; $display("FAIL wd_start got %b want 1", w_core_start); end
      saw_strobe = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (w_web || w_op_done || w_err_timeout) saw_strobe = 1'b1;
      end
      checks++;
      if ({saw_strobe, w_busy} !== 2'b01) begin
         errors++; $display("FAIL wd_before got strobe=%b busy=%b want 0 1", saw_strobe, w_busy);
      end
      tick();
      checks++;
      if (w_err_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout got %b want 1", w_err_timeout); end
      checks++;
      if ({w_busy, w_web, w_op_done} !== 3'b000) begin
         errors++; $display("FAIL wd_abort got %b want 000", {w_busy, w_web, w_op_done});
      end
      tick();
      checks++;
      if ({w_web, w_op_done, w_err_timeout} !== 3'b001) begin
         errors++; $display("FAIL wd_after got %b want 001", {w_web, w_op_done, w_err_timeout});
      end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++;
      if (w_err_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", w_err_timeout); end
   endtask

   task automatic test_reset_mid_op();
      logic [W-1:0] a, b, m;
      a = rnd_wide();
      b = rnd_wide();
      m = rnd_wide();
      send_frame(a);
      send_frame(b);
      send_frame(m);
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b want 1", busy); end
      #2 reset = 1'b1;
      #1;
      exp_a = '0; exp_b = '0; exp_m = '0; exp_mvalid = 1'b0; exp_ovr = 1'b0;
      checks++;
      if ({busy, web, core_start, op_done, err_overrun, err_timeout} !== 6'b0) begin
         errors++; $display("FAIL async_reset_flags got %b want 0", {busy, web, core_start, op_done, err_overrun, err_timeout});
      end
      checks++;
      if ({core_a, core_b} !== {exp_a, exp_b} || core_m !== exp_m || dinb !== '0) begin
         errors++; $display("FAIL async_reset_data got %0h want 0", core_a | core_b | core_m | dinb);
      end
      reset = 1'b0;
      tick();
      run_op(rnd_wide(), rnd_wide(), rnd_wide(), 1'b1, $urandom_range(1, 8), rnd_wide(), 0, 1'b0,
             "after_reset");
   endtask

   initial begin
      reset = 1'b1; doutb = '0; doutb_valid = 1'b0; wd_valid = 1'b0; dinb_read = 1'b0;
      cfg_reuse_mod = 1'b0; core_done = 1'b0; core_result = '0; err_clear = 1'b0;
      wd_core_done = 1'b0;
      exp_a = '0; exp_b = '0; exp_m = '0; exp_mvalid = 1'b0; exp_ovr = 1'b0;
      test_reset();
      test_full_op();
      test_reuse_mod();
      test_collision();
      test_overrun();
      test_watchdog();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
